// File: rtl/video_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_gen_pkg
//   Shared video definitions for the VideoCore output path. It holds the XGA
//   (1024x768@60) raster timing constants and the pixel coordinate widths.
//   Both the timing generator and the SRAM line-buffer fetcher import it, so
//   they agree on coordinate widths and frame geometry.
//   No ports (package).
// ---------------------------------------------------------------------------
package video_timing_gen_pkg;

    // Coordinate widths shared by every consumer of pixel positions.
    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef logic [X_W-1:0] x_t;
    typedef logic [Y_W-1:0] y_t;

    // XGA 1024x768@60 horizontal timing, in pixel clocks.
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

    // XGA vertical timing, in lines.
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

endpackage

// File: rtl/video_timing_gen_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
//   Generic wrapping counter 0..MAX with a synchronous clear and a carry out.
//   The carry is combinational so a second instance can chain on it and step
//   on the same edge that this one wraps.
//   Ports:
//     clk   in  clock
//     rst   in  asynchronous, active-high reset (count -> 0)
//     clr   in  synchronous clear to 0 (takes priority over inc)
//     inc   in  advance by one this cycle
//     count out current count
//     wrap  out high when inc is set and count is at MAX (count -> 0 next)
// ---------------------------------------------------------------------------
module raster_counter #(
    parameter int W   = 11,
    parameter int MAX = 1343
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing for the VideoCore pixel output path. Two chained
//   raster_counters walk h/v position; every output is a registered decode
//   of that position, so outputs describe the previous cycle's (h_cnt, v_cnt).
//   A per-line prefetch request goes to the line-buffer fetcher
//   PREFETCH_LEAD cycles ahead of each visible line.
//   Ports:
//     i_pixel_clk   in   pixel clock
//     i_reset       in   asynchronous, active-high reset
//     i_enable      in   run raster; low clears counters and idles outputs
//     o_hsync       out  horizontal sync, asserted level HSYNC_POL
//     o_vsync       out  vertical sync, asserted level VSYNC_POL
//     o_active      out  high during visible pixels
//     o_x           out  pixel column (0 outside visible area)
//     o_y           out  pixel row (0 outside visible area)
//     o_frame_start out  one-cycle pulse on pixel (0,0)
//     o_line_fetch  out  one-cycle prefetch request
//     o_fetch_line  out  row for the latest request, held until the next one
// ---------------------------------------------------------------------------
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE      = XGA_H_ACTIVE,
    parameter int H_FP          = XGA_H_FP,
    parameter int H_SYNC        = XGA_H_SYNC,
    parameter int H_BP          = XGA_H_BP,
    parameter int V_ACTIVE      = XGA_V_ACTIVE,
    parameter int V_FP          = XGA_V_FP,
    parameter int V_SYNC        = XGA_V_SYNC,
    parameter int V_BP          = XGA_V_BP,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int PREFETCH_LEAD = 64
) (
    input  logic           i_pixel_clk,
    input  logic           i_reset,
    input  logic           i_enable,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_active,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_frame_start,
    output logic           o_line_fetch,
    output logic [Y_W-1:0] o_fetch_line
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_BLANK = H_FP + H_SYNC + H_BP;

    // Region boundaries pre-sized to the counter widths.
    localparam x_t H_VIS    = X_W'(H_ACTIVE);
    localparam x_t HS_START = X_W'(H_ACTIVE + H_FP);
    localparam x_t HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam x_t FETCH_H  = X_W'(H_TOTAL - PREFETCH_LEAD);
    localparam y_t V_VIS    = Y_W'(V_ACTIVE);
    localparam y_t VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam y_t VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam y_t V_LAST   = Y_W'(V_TOTAL - 1);

    // The request must land inside horizontal blanking of the previous line.
    if (PREFETCH_LEAD < 1 || PREFETCH_LEAD > H_BLANK) begin : g_bad_lead
        $fatal(1, "video_timing_gen: PREFETCH_LEAD=%0d outside 1..%0d",
               PREFETCH_LEAD, H_BLANK);
    end

    x_t   h_cnt;
    y_t   v_cnt;
    logic h_wrap;
    // End-of-frame carry: the v counter wraps on its own, nothing consumes it.
    logic unused_v_wrap;

    raster_counter #(.W(X_W), .MAX(H_TOTAL - 1)) u_h_cnt (
        .clk   (i_pixel_clk),
        .rst   (i_reset),
        .clr   (!i_enable),
        .inc   (i_enable),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    raster_counter #(.W(Y_W), .MAX(V_TOTAL - 1)) u_v_cnt (
        .clk   (i_pixel_clk),
        .rst   (i_reset),
        .clr   (!i_enable),
        .inc   (h_wrap),
        .count (v_cnt),
        .wrap  (unused_v_wrap)
    );

    // Decode of the current counter state; registered below.
    logic visible;
    logic hsync_on;
    logic vsync_on;
    logic fetch_hit;
    y_t   target_line;

    assign visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hsync_on    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    // v_cnt only changes on h wrap, so vsync edges fall at h_cnt = 0.
    assign vsync_on    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    // Request the line after this one; from the last line that is row 0.
    assign target_line = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    assign fetch_hit   = (h_cnt == FETCH_H) && (target_line < V_VIS);

    always_ff @(posedge i_pixel_clk or posedge i_reset) begin
        if (i_reset) begin
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_active      <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_line_fetch  <= 1'b0;
            o_fetch_line  <= '0;
        end else if (!i_enable) begin
            // Idle: same values as reset, and the frame in progress is dropped.
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_active      <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_line_fetch  <= 1'b0;
            o_fetch_line  <= '0;
        end else begin
            o_hsync       <= hsync_on ? HSYNC_POL : ~HSYNC_POL;
            o_vsync       <= vsync_on ? VSYNC_POL : ~VSYNC_POL;
            o_active      <= visible;
            o_x           <= visible ? h_cnt : '0;
            o_y           <= visible ? v_cnt : '0;
            o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
            o_line_fetch  <= fetch_hit;
            if (fetch_hit) begin
                o_fetch_line <= target_line;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Self-checking bench for video_timing_gen on a reduced raster so whole
//   frames fit in a short run. A reference model tracks the linear position
//   inside the frame and derives every output from it arithmetically.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HA    = 16;
    localparam int HFP   = 4;
    localparam int HS    = 6;
    localparam int HBP   = 8;
    localparam int VA    = 8;
    localparam int VFP   = 2;
    localparam int VS    = 3;
    localparam int VBP   = 4;
    localparam int LEAD  = 10;
    localparam bit HP    = 1'b0;
    localparam bit VP    = 1'b1;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        act;
        logic [10:0] x;
        logic [9:0]  y;
        logic        fs;
        logic        lf;
        logic [9:0]  fl;
    } vec_t;

    // Idle/reset output image: syncs deasserted, everything else zero.
    localparam vec_t RESET_VEC = {!HP, !VP, 34'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        o_hsync, o_vsync, o_active, o_frame_start, o_line_fetch;
    logic [10:0] o_x;
    logic [9:0]  o_y, o_fetch_line;
    vec_t        dut_vec;
    vec_t        exp_vec;
    int          pos;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .PREFETCH_LEAD(LEAD)
    ) dut (
        .i_pixel_clk   (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_active      (o_active),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_frame_start (o_frame_start),
        .o_line_fetch  (o_line_fetch),
        .o_fetch_line  (o_fetch_line)
    );

    assign dut_vec = {o_hsync, o_vsync, o_active, o_x, o_y,
                      o_frame_start, o_line_fetch, o_fetch_line};

    // Outputs expected for linear frame position p (row = p / HT, col = p % HT).
    // A fetch is due when the position LEAD cycles ahead starts a visible row.
    function automatic vec_t model_out(input int p, input logic [9:0] held);
        vec_t r;
        int   x, y, ahead;
        x      = p % HT;
        y      = p / HT;
        r.act  = (x < HA) && (y < VA);
        r.x    = r.act ? 11'(x) : 11'd0;
        r.y    = r.act ? 10'(y) : 10'd0;
        r.hs   = (x >= HA + HFP && x < HA + HFP + HS) ? HP : !HP;
        r.vs   = (y >= VA + VFP && y < VA + VFP + VS) ? VP : !VP;
        r.fs   = (p == 0);
        ahead  = (p + LEAD) % FRAME;
        r.lf   = (ahead % HT == 0) && (ahead / HT < VA);
        r.fl   = r.lf ? 10'(ahead / HT) : held;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            pos     <= 0;
            exp_vec <= RESET_VEC;
        end else begin
            exp_vec <= model_out(pos, exp_vec.fl);
            pos     <= (pos + 1) % FRAME;
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== RESET_VEC) begin
                fails++;
                $display("FAIL reset_hold got=%h exp=%h", dut_vec, RESET_VEC);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (!(o_frame_start === 1'b1 && o_active === 1'b1 && o_x === 11'd0 && o_y === 10'd0)) begin
            fails++;
            $display("FAIL reset_first_pixel got fs=%b act=%b x=%0d y=%0d exp fs=1 act=1 x=0 y=0",
                     o_frame_start, o_active, o_x, o_y);
        end
    endtask

    // Two frames: every cycle against the model, plus timing measurements.
    task automatic test_frame;
        int act_cnt = 0, hs_cnt = 0, vs_cnt = 0, lf_cnt = 0, fs_cnt = 0;
        int run = 0, hs_run = 0, rise_cyc = -1, last_fetch = -1;
        int next_line = 1;
        bit prev_act = 1'b1;
        bit prev_hs = !HP;
        for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL frame_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
            end
            if (o_active) act_cnt++;
            if (o_hsync === HP) hs_cnt++;
            if (o_vsync === VP) vs_cnt++;
            if (o_frame_start) fs_cnt++;
            if (o_line_fetch) begin
                lf_cnt++;
                last_fetch = cyc;
                tests++;
                if (o_fetch_line !== 10'(next_line)) begin
                    fails++;
                    $display("FAIL fetch_sequence got=%0d exp=%0d", o_fetch_line, next_line);
                end
                next_line = (next_line + 1) % VA;
            end
            if (o_active && !prev_act) begin
                run      = 1;
                rise_cyc = cyc;
                tests++;
                if (last_fetch < 0 || cyc - last_fetch != LEAD) begin
                    fails++;
                    $display("FAIL fetch_lead got=%0d exp=%0d", cyc - last_fetch, LEAD);
                end
            end else if (o_active && run > 0) begin
                run++;
            end
            if (!o_active && prev_act && run > 0) begin
                tests++;
                if (run != HA) begin
                    fails++;
                    $display("FAIL active_run got=%0d exp=%0d", run, HA);
                end
            end
            if (o_hsync === HP && prev_hs !== HP && rise_cyc >= 0 && cyc - rise_cyc < HT) begin
                tests++;
                if (cyc - rise_cyc != HA + HFP) begin
                    fails++;
                    $display("FAIL hsync_lag got=%0d exp=%0d", cyc - rise_cyc, HA + HFP);
                end
            end
            if (o_hsync === HP) begin
                hs_run++;
            end else if (prev_hs === HP) begin
                tests++;
                if (hs_run != HS) begin
                    fails++;
                    $display("FAIL hsync_width got=%0d exp=%0d", hs_run, HS);
                end
                hs_run = 0;
            end
            prev_act = o_active;
            prev_hs  = o_hsync;
        end
        tests++;
        if (act_cnt != 2 * HA * VA) begin
            fails++; $display("FAIL active_total got=%0d exp=%0d", act_cnt, 2 * HA * VA);
        end
        tests++;
        if (hs_cnt != 2 * HS * VT) begin
            fails++; $display("FAIL hsync_total got=%0d exp=%0d", hs_cnt, 2 * HS * VT);
        end
        tests++;
        if (vs_cnt != 2 * VS * HT) begin
            fails++; $display("FAIL vsync_total got=%0d exp=%0d", vs_cnt, 2 * VS * HT);
        end
        tests++;
        if (lf_cnt != 2 * VA) begin
            fails++; $display("FAIL fetch_total got=%0d exp=%0d", lf_cnt, 2 * VA);
        end
        tests++;
        if (fs_cnt != 2) begin
            fails++; $display("FAIL frame_start_total got=%0d exp=2", fs_cnt);
        end
    endtask

    task automatic test_coords;
        int  idx = 0;
        bit  found = 1'b0;
        bit  last_seen = 1'b0;
        bit  done = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            found = (o_frame_start === 1'b1);
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL coords_frame_start got=timeout exp=pulse");
        end
        for (int c = 0; c < FRAME && found && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (o_active) begin
                if (idx == 5 * HA + 4) begin
                    tests++;
                    if (o_x !== 11'd4 || o_y !== 10'd5) begin
                        fails++; $display("FAIL coords_row5 got x=%0d y=%0d exp x=4 y=5", o_x, o_y);
                    end
                end
                if (idx == HA * VA - 1) begin
                    last_seen = 1'b1;
                    tests++;
                    if (o_x !== 11'(HA - 1) || o_y !== 10'(VA - 1)) begin
                        fails++; $display("FAIL coords_last got x=%0d y=%0d exp x=%0d y=%0d", o_x, o_y, HA - 1, VA - 1);
                    end
                end
                idx++;
            end else if (last_seen) begin
                done = 1'b1;
                tests++;
                if (o_x !== 11'd0 || o_y !== 10'd0) begin
                    fails++; $display("FAIL coords_blank got x=%0d y=%0d exp x=0 y=0", o_x, o_y);
                end
            end
        end
        tests++;
        if (idx != HA * VA) begin
            fails++; $display("FAIL coords_count got=%0d exp=%0d", idx, HA * VA);
        end
    endtask

    task automatic test_reset_midframe;
        bit found = 1'b0;
        int lf_cnt = 0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            found = (o_active === 1'b1 && o_y === 10'd4 && o_x === 11'd7);
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL midreset_wait got=timeout exp=pixel(7,4)");
        end
        rst = 1'b1;
        #1;
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++; $display("FAIL midreset_async got=%h exp=%h", dut_vec, RESET_VEC);
        end
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== RESET_VEC) begin
                fails++; $display("FAIL midreset_hold got=%h exp=%h", dut_vec, RESET_VEC);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (o_frame_start !== 1'b1 || o_y !== 10'd0 || o_x !== 11'd0 || o_line_fetch !== 1'b0) begin
            fails++;
            $display("FAIL midreset_restart got fs=%b x=%0d y=%0d lf=%b exp fs=1 x=0 y=0 lf=0",
                     o_frame_start, o_x, o_y, o_line_fetch);
        end
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL midreset_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (o_line_fetch) begin
                lf_cnt++;
                if (lf_cnt == 1) begin
                    tests++;
                    if (o_fetch_line !== 10'd1) begin
                        fails++; $display("FAIL midreset_first_fetch got=%0d exp=1", o_fetch_line);
                    end
                end
            end
        end
    endtask

    task automatic test_enable_drop;
        bit found = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            found = (o_active === 1'b1 && o_x === 11'd8 && o_y === 10'd2);
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL idle_wait got=timeout exp=pixel(8,2)");
        end
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== RESET_VEC) begin
                fails++; $display("FAIL idle_outputs got=%h exp=%h", dut_vec, RESET_VEC);
            end
        end
        en = 1'b1;
        @(negedge clk);
        tests++;
        if (o_frame_start !== 1'b1 || o_active !== 1'b1 || o_x !== 11'd0 || o_y !== 10'd0) begin
            fails++;
            $display("FAIL idle_restart got fs=%b act=%b x=%0d y=%0d exp fs=1 act=1 x=0 y=0",
                     o_frame_start, o_active, o_x, o_y);
        end
        for (int c = 0; c < 3 * HT; c++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL idle_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
    endtask

    // Random reset pulses and enable drops over several frames.
    task automatic test_random;
        int hold = 0;
        int r;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (rst) begin
                if (hold == 0) rst = 1'b0; else hold--;
            end else if (!en) begin
                if (hold == 0) en = 1'b1; else hold--;
            end else begin
                r = int'($urandom_range(0, 1999));
                if (r < 3) begin
                    rst  = 1'b1;
                    hold = int'($urandom_range(0, 3));
                end else if (r < 6) begin
                    en   = 1'b0;
                    hold = int'($urandom_range(0, 20));
                end
            end
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_coords();
        test_reset_midframe();
        test_enable_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
